inverse_butterfly_unit: RTL

Radix-2 decimation-in-frequency (Gentleman-Sande) inverse butterfly for the IFFT path. It is the counterpart of the forward DIT butterfly:
- out1 = (A+B)/2
- out2 = (A−B)·conj(W)/2

It is sequential and area-lean. One shared signed multiplier is time-multiplexed over four cycles under an FSM. Valid/ready handshakes sit on the input and output sides so the block can chain between IFFT stage buffers.

---
 rtl/fft_pkg.sv | 78 +++++++
 rtl/fft_shared_mult.sv | 102 ++++++++++
 rtl/inverse_butterfly_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fft_pkg
// Brief    : Shared types and helpers for the radix-2 FFT/IFFT butterflies.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_H             = c_DEFAULT_WIDTH / 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M0   = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_OUT  = 3'd5
    } bfly_state_t;

    typedef enum logic [1:0] {
        OP_DR_WR = 2'd0,
        OP_DI_WI = 2'd1,
        OP_DI_WR = 2'd2,
        OP_DR_WI = 2'd3
    } mult_op_t;

    typedef enum logic [1:0] {
        ACC_HOLD = 2'd0,
        ACC_LOAD = 2'd1,
        ACC_ADD  = 2'd2,
        ACC_SUB  = 2'd3
    } acc_mode_t;

    typedef enum logic {
        ACC_RE = 1'b0,
        ACC_IM = 1'b1
    } acc_sel_t;

    // Clip a signed value to the range of an h-bit two's complement half.
    function automatic logic signed [63:0] sat_half(input logic signed [63:0] value,
                                                    input int h);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (h - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (h - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

    // Sign-extended real half (bits [h-1:0]) of a packed complex word.
    function automatic logic signed [63:0] unpack_re(input logic [63:0] pk, input int h);
        logic [63:0] v;
        v = pk << (64 - h);
        return $signed(v) >>> (64 - h);
    endfunction

    // Sign-extended imaginary half (bits [2h-1:h]) of a packed complex word.
    function automatic logic signed [63:0] unpack_im(input logic [63:0] pk, input int h);
        logic [63:0] v;
        v = pk << (64 - 2 * h);
        return $signed(v) >>> (64 - h);
    endfunction

    function automatic logic [63:0] pack_halves(input logic [63:0] re,
                                                input logic [63:0] im,
                                                input int h);
        logic [63:0] mask;
        mask = (64'd1 << h) - 64'd1;
        return ((im & mask) << h) | (re & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_shared_mult.sv
`default_nettype none
// ============================================================================
// Module   : fft_shared_mult
// Brief    : One signed multiplier over registered D/W operands feeding two
//            accumulators with load/add/sub control.
// Revision : 1.0 - initial release
// ============================================================================
module fft_shared_mult
    import fft_pkg::*;
#(
    parameter int HALF  = c_H,
    parameter int ACC_W = 2 * HALF + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load_ops,
    input  logic signed [HALF:0]    i_d_re,
    input  logic signed [HALF:0]    i_d_im,
    input  logic signed [HALF-1:0]  i_w_re,
    input  logic signed [HALF-1:0]  i_w_im,
    input  mult_op_t                i_op_sel,
    input  acc_sel_t                i_acc_sel,
    input  acc_mode_t               i_acc_mode,
    output logic signed [ACC_W-1:0] o_acc_re_next,
    output logic signed [ACC_W-1:0] o_acc_im_next
);

    logic signed [HALF:0]    r_d_re;
    logic signed [HALF:0]    r_d_im;
    logic signed [HALF-1:0]  r_w_re;
    logic signed [HALF-1:0]  r_w_im;
    logic signed [ACC_W-1:0] r_acc_re;
    logic signed [ACC_W-1:0] r_acc_im;

    logic signed [HALF:0]    w_op_d;
    logic signed [HALF-1:0]  w_op_w;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_acc_cur;
    logic signed [ACC_W-1:0] w_acc_new;

    always_comb begin
        w_op_d = r_d_re;
        w_op_w = r_w_re;
        case (i_op_sel)
            OP_DI_WI: begin
                w_op_d = r_d_im;
                w_op_w = r_w_im;
            end
            OP_DI_WR: begin
                w_op_d = r_d_im;
                w_op_w = r_w_re;
            end
            OP_DR_WI: begin
                w_op_d = r_d_re;
                w_op_w = r_w_im;
            end
            default: ;
        endcase
    end

    // Operands widened to the accumulator width so a -1.0 twiddle cannot overflow.
    assign w_prod = ACC_W'(w_op_d) * ACC_W'(w_op_w);

    always_comb begin
        w_acc_cur     = (i_acc_sel == ACC_IM) ? r_acc_im : r_acc_re;
        w_acc_new     = w_acc_cur;
        o_acc_re_next = r_acc_re;
        o_acc_im_next = r_acc_im;
        case (i_acc_mode)
            ACC_LOAD: w_acc_new = w_prod;
            ACC_ADD:  w_acc_new = w_acc_cur + w_prod;
            ACC_SUB:  w_acc_new = w_acc_cur - w_prod;
            default:  w_acc_new = w_acc_cur;
        endcase
        if (i_acc_sel == ACC_IM)
            o_acc_im_next = w_acc_new;
        else
            o_acc_re_next = w_acc_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_re   <= '0;
            r_d_im   <= '0;
            r_w_re   <= '0;
            r_w_im   <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else begin
            if (i_load_ops) begin
                r_d_re <= i_d_re;
                r_d_im <= i_d_im;
                r_w_re <= i_w_re;
                r_w_im <= i_w_im;
            end
            r_acc_re <= o_acc_re_next;
            r_acc_im <= o_acc_im_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inverse_butterfly_unit.sv
`default_nettype none
// ============================================================================
// Module   : inverse_butterfly_unit
// Brief    : Radix-2 DIF inverse butterfly: (A+B)/2^S and (A-B)*conj(W)/2^S,
//            one shared multiplier over four cycles, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module inverse_butterfly_unit
    import fft_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int SCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [WIDTH-1:0] twiddle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output1,
    output logic [WIDTH-1:0] output2,
    output logic             out_sat
);

    localparam int c_HALF  = WIDTH / 2;
    localparam int c_SW    = c_HALF + 1;
    localparam int c_ACC_W = 2 * c_HALF + 2;
    localparam int c_SHIFT = c_HALF - 1 + SCALE;

    bfly_state_t r_state;
    bfly_state_t w_state_next;

    logic                      w_capture;
    logic                      w_result_load;
    mult_op_t                  w_op_sel;
    acc_sel_t                  w_acc_sel;
    acc_mode_t                 w_acc_mode;

    logic signed [63:0]        w_a_re, w_a_im, w_b_re, w_b_im, w_t_re, w_t_im;
    logic signed [c_HALF:0]    w_d_re, w_d_im;
    logic signed [c_HALF-1:0]  w_w_re, w_w_im;
    logic signed [c_SW-1:0]    r_s_re, r_s_im;

    logic signed [c_ACC_W-1:0] w_acc_re_next, w_acc_im_next;
    logic signed [c_ACC_W-1:0] w_re_shift, w_im_shift;
    logic signed [c_SW-1:0]    w_s_re_shift, w_s_im_shift;
    logic signed [63:0]        w_re_wide, w_im_wide;
    logic signed [63:0]        w_o2_re, w_o2_im, w_o1_re, w_o1_im;
    logic                      w_clip;

    assign w_a_re = unpack_re(64'(input1), c_HALF);
    assign w_a_im = unpack_im(64'(input1), c_HALF);
    assign w_b_re = unpack_re(64'(input2), c_HALF);
    assign w_b_im = unpack_im(64'(input2), c_HALF);
    assign w_t_re = unpack_re(64'(twiddle), c_HALF);
    assign w_t_im = unpack_im(64'(twiddle), c_HALF);

    assign w_d_re = c_SW'(w_a_re - w_b_re);
    assign w_d_im = c_SW'(w_a_im - w_b_im);
    assign w_w_re = c_HALF'(w_t_re);
    assign w_w_im = c_HALF'(w_t_im);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        w_capture     = 1'b0;
        w_result_load = 1'b0;
        w_op_sel      = OP_DR_WR;
        w_acc_sel     = ACC_RE;
        w_acc_mode    = ACC_HOLD;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_M0;
                end
            end
            ST_M0: begin
                w_op_sel     = OP_DR_WR;
                w_acc_mode   = ACC_LOAD;
                w_state_next = ST_M1;
            end
            ST_M1: begin
                w_op_sel     = OP_DI_WI;
                w_acc_mode   = ACC_ADD;
                w_state_next = ST_M2;
            end
            ST_M2: begin
                w_op_sel     = OP_DI_WR;
                w_acc_sel    = ACC_IM;
                w_acc_mode   = ACC_LOAD;
                w_state_next = ST_M3;
            end
            ST_M3: begin
                w_op_sel      = OP_DR_WI;
                w_acc_sel     = ACC_IM;
                w_acc_mode    = ACC_SUB;
                w_result_load = 1'b1;
                w_state_next  = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    fft_shared_mult #(
        .HALF  (c_HALF),
        .ACC_W (c_ACC_W)
    ) u_mult (
        .clk           (clk),
        .rst           (reset),
        .i_load_ops    (w_capture),
        .i_d_re        (w_d_re),
        .i_d_im        (w_d_im),
        .i_w_re        (w_w_re),
        .i_w_im        (w_w_im),
        .i_op_sel      (w_op_sel),
        .i_acc_sel     (w_acc_sel),
        .i_acc_mode    (w_acc_mode),
        .o_acc_re_next (w_acc_re_next),
        .o_acc_im_next (w_acc_im_next)
    );

    // The imaginary accumulator finishes on the same edge the result is
    // registered, so the output stage works from the next-state values.
    assign w_re_shift   = w_acc_re_next >>> c_SHIFT;
    assign w_im_shift   = w_acc_im_next >>> c_SHIFT;
    assign w_re_wide    = 64'(w_re_shift);
    assign w_im_wide    = 64'(w_im_shift);
    assign w_o2_re      = sat_half(w_re_wide, c_HALF);
    assign w_o2_im      = sat_half(w_im_wide, c_HALF);
    assign w_clip       = (w_o2_re != w_re_wide) || (w_o2_im != w_im_wide);

    assign w_s_re_shift = r_s_re >>> SCALE;
    assign w_s_im_shift = r_s_im >>> SCALE;
    assign w_o1_re      = sat_half(64'(w_s_re_shift), c_HALF);
    assign w_o1_im      = sat_half(64'(w_s_im_shift), c_HALF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_re  <= '0;
            r_s_im  <= '0;
            output1 <= '0;
            output2 <= '0;
            out_sat <= 1'b0;
        end else begin
            if (w_capture) begin
                r_s_re <= c_SW'(w_a_re + w_b_re);
                r_s_im <= c_SW'(w_a_im + w_b_im);
            end
            if (w_result_load) begin
                output1 <= WIDTH'(pack_halves(w_o1_re, w_o1_im, c_HALF));
                output2 <= WIDTH'(pack_halves(w_o2_re, w_o2_im, c_HALF));
                out_sat <= w_clip;
            end
        end
    end

endmodule
`default_nettype wire
